// File: rtl/event_stream_pkg.sv
// Shared types and header layout for the event stream receive path.
package event_stream_pkg;

  typedef enum logic [1:0] {
    ST_HDR    = 2'd0,
    ST_DATA   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_NOTIFY = 2'd3
  } state_t;

  // Header word: seqno[31:16], eventsz[15:12], aux[11:6], eventno[5:0]
  localparam int HDR_SEQ_LSB = 16;
  localparam int HDR_SEQ_W   = 16;
  localparam int HDR_SZ_LSB  = 12;
  localparam int HDR_SZ_W    = 4;
  localparam int HDR_AUX_LSB = 6;
  localparam int HDR_AUX_W   = 6;
  localparam int HDR_EV_LSB  = 0;
  localparam int HDR_EV_W    = 6;

  localparam int REQ_LEN_BITS = 2;

endpackage

// File: rtl/event_stream_parser_sat_cnt16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/event_stream_parser.sv
// Parses framed event stream into mirror writes plus one notification per
// well-formed frame, with sequence/length/header error counters.
module event_stream_parser
  import event_stream_pkg::*;
#(
  parameter int             EVENT_COUNT_BITS = 4,
  parameter int             ADDR_WIDTH       = 6,
  parameter int             DATA_WIDTH       = 32,
  parameter int             AUX_WIDTH        = 2,
  parameter logic [1023:0]  A_EVENT_ADDRS    = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       s_evd_data,
  input  logic                        s_evd_last,
  input  logic                        s_evd_valid,
  output logic                        s_evd_ready,
  output logic [ADDR_WIDTH-3:0]       m_wr_addr,
  output logic [DATA_WIDTH-1:0]       m_wr_data,
  output logic                        m_wr_valid,
  input  logic                        m_wr_ready,
  output logic [EVENT_COUNT_BITS-1:0] m_evt_data,
  output logic [AUX_WIDTH-1:0]        m_evt_user,
  output logic [15:0]                 m_evt_seqno,
  output logic                        m_evt_valid,
  input  logic                        m_evt_ready,
  output logic [15:0]                 stat_seq_err,
  output logic [15:0]                 stat_len_err,
  output logic [15:0]                 stat_hdr_err
);

  localparam int WA  = ADDR_WIDTH - 2;
  localparam int NEV = 2 ** EVENT_COUNT_BITS;

  state_t                      state;
  state_t                      state_nxt;
  logic [WA-1:0]               wr_ptr;
  logic [REQ_LEN_BITS-1:0]     rem;
  logic                        sync;
  logic [15:0]                 exp_seq;
  logic [WA-1:0]               base_tbl [NEV];

  logic [HDR_SEQ_W-1:0]        hdr_seq;
  logic [HDR_EV_W-1:0]         hdr_ev;
  logic                        hdr_bad;
  logic                        hdr_beat;
  logic                        data_beat;
  logic                        evt_done;
  logic                        seq_inc;
  logic                        len_inc;
  logic                        hdr_inc;

  for (genvar g = 0; g < NEV; g++) begin : g_base
    assign base_tbl[g] = A_EVENT_ADDRS[32*g +: WA];
  end

  assign hdr_seq   = s_evd_data[HDR_SEQ_LSB +: HDR_SEQ_W];
  assign hdr_ev    = s_evd_data[HDR_EV_LSB +: HDR_EV_W];
  assign hdr_bad   = |(hdr_ev >> EVENT_COUNT_BITS);
  assign hdr_beat  = (state == ST_HDR) && s_evd_valid;
  assign data_beat = (state == ST_DATA) && s_evd_valid && s_evd_ready;
  assign evt_done  = m_evt_valid && m_evt_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR: begin
        if (s_evd_valid) begin
          if (hdr_bad) begin
            state_nxt = s_evd_last ? ST_HDR : ST_FLUSH;
          end else if (!s_evd_last) begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (data_beat) begin
          if (s_evd_last) begin
            state_nxt = (rem == '0) ? ST_NOTIFY : ST_HDR;
          end else if (rem == '0) begin
            state_nxt = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (s_evd_valid && s_evd_last) begin
          state_nxt = ST_HDR;
        end
      end
      ST_NOTIFY: begin
        if (evt_done) begin
          state_nxt = ST_HDR;
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // The notification waits for the final mirror write to drain.
  always_comb begin
    s_evd_ready = 1'b0;
    m_evt_valid = 1'b0;
    case (state)
      ST_HDR, ST_FLUSH: s_evd_ready = 1'b1;
      ST_DATA:          s_evd_ready = ~m_wr_valid | m_wr_ready;
      ST_NOTIFY:        m_evt_valid = ~m_wr_valid;
      default:          s_evd_ready = 1'b0;
    endcase
  end

  // wr_ptr runs ahead of m_wr_addr so a new header never disturbs a pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_evt_data  <= '0;
      m_evt_user  <= '0;
      m_evt_seqno <= '0;
      wr_ptr      <= '0;
      rem         <= '0;
      sync        <= 1'b0;
      exp_seq     <= '0;
    end else if (hdr_beat) begin
      m_evt_data  <= hdr_ev[EVENT_COUNT_BITS-1:0];
      m_evt_user  <= s_evd_data[HDR_AUX_LSB +: AUX_WIDTH];
      m_evt_seqno <= hdr_seq;
      wr_ptr      <= base_tbl[hdr_ev[EVENT_COUNT_BITS-1:0]];
      rem         <= s_evd_data[HDR_SZ_LSB +: REQ_LEN_BITS];
      sync        <= 1'b1;
      exp_seq     <= hdr_seq + 16'd1;
    end else if (data_beat) begin
      wr_ptr      <= wr_ptr + WA'(1);
      rem         <= rem - REQ_LEN_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_wr_valid <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_data  <= '0;
    end else if (data_beat) begin
      m_wr_valid <= 1'b1;
      m_wr_addr  <= wr_ptr;
      m_wr_data  <= s_evd_data;
    end else if (m_wr_ready) begin
      m_wr_valid <= 1'b0;
    end
  end

  assign seq_inc = hdr_beat && sync && (hdr_seq != exp_seq);
  assign hdr_inc = hdr_beat && hdr_bad;
  assign len_inc = (hdr_beat && !hdr_bad && s_evd_last) ||
                   (data_beat && (rem != '0) && s_evd_last) ||
                   (data_beat && (rem == '0) && !s_evd_last);

  sat_cnt16 u_seq_cnt (.clk(clk), .rst_n(rst_n), .inc(seq_inc), .count(stat_seq_err));
  sat_cnt16 u_len_cnt (.clk(clk), .rst_n(rst_n), .inc(len_inc), .count(stat_len_err));
  sat_cnt16 u_hdr_cnt (.clk(clk), .rst_n(rst_n), .inc(hdr_inc), .count(stat_hdr_err));

endmodule

// File: tb/tb_event_stream_parser.sv
// Directed plus randomized frames checked against a frame-level model of the parser.
module tb_event_stream_parser;

  localparam int ECB  = 4;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int AUXW = 2;
  localparam int WA   = AW - 2;

  function automatic logic [WA-1:0] baseFor(input int n);
    if (n == 3) return 4'h8;
    if (n == 5) return 4'hE;
    return WA'((n * 7 + 1) % 16);
  endfunction

  function automatic logic [1023:0] makeAddrs();
    logic [1023:0] v;
    v = '0;
    for (int n = 0; n < 16; n++) v[32*n +: WA] = baseFor(n);
    return v;
  endfunction

  localparam logic [1023:0] ADDRS = makeAddrs();

  logic            clk;
  logic            rst_n;
  logic [DW-1:0]   s_evd_data;
  logic            s_evd_last;
  logic            s_evd_valid;
  logic            s_evd_ready;
  logic [WA-1:0]   m_wr_addr;
  logic [DW-1:0]   m_wr_data;
  logic            m_wr_valid;
  logic            m_wr_ready;
  logic [ECB-1:0]  m_evt_data;
  logic [AUXW-1:0] m_evt_user;
  logic [15:0]     m_evt_seqno;
  logic            m_evt_valid;
  logic            m_evt_ready;
  logic [15:0]     stat_seq_err;
  logic [15:0]     stat_len_err;
  logic [15:0]     stat_hdr_err;

  event_stream_parser #(
    .EVENT_COUNT_BITS(ECB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .AUX_WIDTH(AUXW), .A_EVENT_ADDRS(ADDRS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_evd_data(s_evd_data), .s_evd_last(s_evd_last),
    .s_evd_valid(s_evd_valid), .s_evd_ready(s_evd_ready),
    .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_evt_data(m_evt_data), .m_evt_user(m_evt_user),
    .m_evt_seqno(m_evt_seqno), .m_evt_valid(m_evt_valid),
    .m_evt_ready(m_evt_ready),
    .stat_seq_err(stat_seq_err), .stat_len_err(stat_len_err),
    .stat_hdr_err(stat_hdr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WA-1:0] a;
    logic [31:0]   d;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  bit          bpMode = 0;
  wr_t         wrQ[$];
  logic [21:0] evQ[$];
  logic [31:0] frameBeats[$];
  logic [31:0] hdrWord;
  int          expSeq = 0;
  bit          synced = 0;
  int          mSeq = 0;
  int          mLen = 0;
  int          mHdr = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Sink-side monitor: every handshake must match the next expected item,
  // and a stalled valid must hold its payload.
  wr_t         mw;
  logic [21:0] me;
  logic        pWv, pWr, pEv, pEr;
  logic [WA-1:0] pWa;
  logic [31:0] pWd;
  logic [21:0] pE;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pWv && !pWr) begin
        checkOutput("wr_hold_valid", m_wr_valid, 1);
        checkOutput("wr_hold_payload", {m_wr_addr, m_wr_data}, {pWa, pWd});
      end
      if (pEv && !pEr) begin
        checkOutput("evt_hold_valid", m_evt_valid, 1);
        checkOutput("evt_hold_payload", {m_evt_data, m_evt_user, m_evt_seqno}, pE);
      end
      if (m_wr_valid && m_wr_ready) begin
        checkOutput("wr_expected_pending", wrQ.size() != 0, 1);
        if (wrQ.size() != 0) begin
          mw = wrQ.pop_front();
          checkOutput("wr_addr", m_wr_addr, mw.a);
          checkOutput("wr_data", m_wr_data, mw.d);
        end
      end
      if (m_evt_valid && m_evt_ready) begin
        checkOutput("evt_expected_pending", evQ.size() != 0, 1);
        if (evQ.size() != 0) begin
          me = evQ.pop_front();
          checkOutput("evt_fields", {m_evt_data, m_evt_user, m_evt_seqno}, me);
        end
      end
      pWv = m_wr_valid;  pWr = m_wr_ready;  pWa = m_wr_addr;  pWd = m_wr_data;
      pEv = m_evt_valid; pEr = m_evt_ready; pE  = {m_evt_data, m_evt_user, m_evt_seqno};
    end else begin
      pWv = 1'b0;
      pEv = 1'b0;
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (bpMode) begin
      m_wr_ready  = ($urandom_range(0, 9) < 7);
      m_evt_ready = ($urandom_range(0, 9) < 6);
    end
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic l);
    bit done;
    int guard;
    done  = 0;
    guard = 0;
    if (bpMode && ($urandom_range(0, 3) == 0)) stepCycle();
    s_evd_data  = d;
    s_evd_last  = l;
    s_evd_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = s_evd_ready;
      stepCycle();
      guard++;
      if (!done && guard > 300) begin
        $display("[TB] FAIL beat_timeout observed=stalled expected=accepted");
        $fatal(1, "[TB] stream beat never accepted");
      end
    end
    s_evd_valid = 1'b0;
    s_evd_last  = 1'b0;
  endtask

  task automatic modelSeq(input int seq);
    if (synced && (seq != expSeq)) mSeq = sat(mSeq);
    synced = 1;
    expSeq = (seq + 1) % 65536;
  endtask

  // Frame-level reference: which words land where, and whether it notifies.
  task automatic modelFrame(input int seq, input int sz, input int aux, input int ev, input int k);
    int len;
    int nw;
    logic [31:0] s32, z32, a32, e32;
    wr_t w;
    s32 = seq; z32 = sz; a32 = aux; e32 = ev;
    hdrWord = {s32[15:0], z32[3:0], a32[5:0], e32[5:0]};
    frameBeats.delete();
    for (int i = 0; i < k; i++) frameBeats.push_back($urandom);
    modelSeq(seq);
    len = (sz % 4) + 1;
    if (ev >= 16) begin
      mHdr = sat(mHdr);
    end else if (k == 0) begin
      mLen = sat(mLen);
    end else begin
      nw = (k < len) ? k : len;
      for (int i = 0; i < nw; i++) begin
        w.a = WA'((int'(baseFor(ev)) + i) % 16);
        w.d = frameBeats[i];
        wrQ.push_back(w);
      end
      if (k == len) evQ.push_back({e32[3:0], a32[1:0], s32[15:0]});
      else          mLen = sat(mLen);
    end
  endtask

  task automatic driveFrame();
    sendBeat(hdrWord, frameBeats.size() == 0);
    for (int i = 0; i < frameBeats.size(); i++)
      sendBeat(frameBeats[i], i == frameBeats.size() - 1);
  endtask

  task automatic applyStimulus(input int seq, input int sz, input int aux, input int ev, input int k);
    modelFrame(seq, sz, aux, ev, k);
    driveFrame();
  endtask

  task automatic waitDrain();
    int g;
    g = 0;
    while ((wrQ.size() != 0 || evQ.size() != 0) && g < 500) begin
      stepCycle();
      g++;
    end
    checkOutput("drain", wrQ.size() + evQ.size(), 0);
    stepCycle();
    stepCycle();
  endtask

  task automatic checkStats();
    checkOutput("stat_seq_err", stat_seq_err, mSeq);
    checkOutput("stat_len_err", stat_len_err, mLen);
    checkOutput("stat_hdr_err", stat_hdr_err, mHdr);
  endtask

  task automatic checkReset();
    checkOutput("rst_s_ready", s_evd_ready, 1);
    checkOutput("rst_wr_valid", m_wr_valid, 0);
    checkOutput("rst_evt_valid", m_evt_valid, 0);
    checkOutput("rst_wr_addr", m_wr_addr, 0);
    checkOutput("rst_wr_data", m_wr_data, 0);
    checkOutput("rst_evt_fields", {m_evt_data, m_evt_user, m_evt_seqno}, 0);
    checkOutput("rst_stats", {stat_seq_err, stat_len_err, stat_hdr_err}, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int rs, rsz, rk, rev, rlen;

  initial begin
    rst_n       = 1'b0;
    s_evd_data  = '0;
    s_evd_last  = 1'b0;
    s_evd_valid = 1'b0;
    m_wr_ready  = 1'b1;
    m_evt_ready = 1'b1;
    repeat (3) stepCycle();
    checkReset();
    rst_n = 1'b1;
    stepCycle();

    // Basic frame with explicit latency checks: ev3 base 0x8, seq 5, sz1, aux1
    $display("[TB] basic frame");
    modelFrame(5, 1, 1, 3, 2);
    sendBeat(hdrWord, 1'b0);
    sendBeat(frameBeats[0], 1'b0);
    checkOutput("wr_latency_valid", m_wr_valid, 1);
    checkOutput("wr_first_addr", m_wr_addr, 4'h8);
    sendBeat(frameBeats[1], 1'b1);
    checkOutput("notify_not_yet", m_evt_valid, 0);
    checkOutput("notify_blocks_stream", s_evd_ready, 0);
    stepCycle();
    checkOutput("notify_rise", m_evt_valid, 1);
    checkOutput("notify_seqno", m_evt_seqno, 16'd5);
    waitDrain();
    checkStats();

    $display("[TB] sequence gap");
    applyStimulus(6, 0, 2, 1, 1);
    applyStimulus(7, 0, 2, 1, 1);
    applyStimulus(9, 0, 2, 1, 1);
    applyStimulus(10, 0, 2, 1, 1);
    waitDrain();
    checkOutput("seq_err_one", stat_seq_err, 1);
    checkStats();

    $display("[TB] early last and overlong frame");
    applyStimulus(11, 2, 0, 2, 2);
    applyStimulus(12, 2, 0, 2, 3);
    waitDrain();
    checkOutput("len_err_early", stat_len_err, 1);
    applyStimulus(13, 0, 0, 4, 4);
    waitDrain();
    checkOutput("len_err_long", stat_len_err, 2);

    $display("[TB] illegal event and backpressure");
    applyStimulus(14, 1, 3, 20, 2);
    waitDrain();
    checkOutput("hdr_err_one", stat_hdr_err, 1);
    m_wr_ready  = 1'b0;
    m_evt_ready = 1'b0;
    modelFrame(15, 2, 1, 3, 3);
    fork
      driveFrame();
      begin
        repeat (10) stepCycle();
        checkOutput("stall_wr_valid", m_wr_valid, 1);
        m_wr_ready  = 1'b1;
        m_evt_ready = 1'b1;
      end
    join
    waitDrain();
    m_evt_ready = 1'b0;
    applyStimulus(16, 0, 2, 6, 1);
    repeat (10) stepCycle();
    checkOutput("stall_evt_valid", m_evt_valid, 1);
    checkOutput("stall_evt_blocks", s_evd_ready, 0);
    m_evt_ready = 1'b1;
    waitDrain();

    $display("[TB] address wrap");
    applyStimulus(17, 3, 0, 5, 4);
    waitDrain();
    checkOutput("wrap_last_addr", m_wr_addr, 4'h1);
    checkStats();

    $display("[TB] reset mid-frame");
    modelFrame(18, 3, 0, 5, 2);
    evQ.delete();
    sendBeat(hdrWord, 1'b0);
    sendBeat(frameBeats[0], 1'b0);
    sendBeat(frameBeats[1], 1'b0);
    stepCycle();
    rst_n = 1'b0;
    stepCycle();
    stepCycle();
    checkReset();
    checkOutput("reset_writes_done", wrQ.size(), 0);
    mSeq = 0; mLen = 0; mHdr = 0; synced = 0;
    rst_n = 1'b1;
    stepCycle();
    applyStimulus(16'h1234, 1, 1, 3, 2);
    waitDrain();
    checkOutput("sync_cleared", stat_seq_err, 0);

    $display("[TB] random frames");
    bpMode = 1;
    for (int f = 0; f < 120; f++) begin
      rev  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 63)) : int'($urandom_range(0, 15));
      rsz  = $urandom_range(0, 15);
      rlen = (rsz % 4) + 1;
      case ($urandom_range(0, 9))
        0:       rk = 0;
        1:       rk = (rlen > 1) ? int'($urandom_range(1, rlen - 1)) : rlen;
        2:       rk = rlen + int'($urandom_range(1, 3));
        default: rk = rlen;
      endcase
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : expSeq;
      applyStimulus(rs, rsz, $urandom_range(0, 63), rev, rk);
    end
    bpMode      = 0;
    m_wr_ready  = 1'b1;
    m_evt_ready = 1'b1;
    waitDrain();
    checkStats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
